glb_proc_ring_head: RTL and testbench



---
 rtl/glb_proc_ring_head.sv | 168 ++++++++++++++++
 tb/tb_glb_proc_ring_head.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_proc_ring_head.sv
// Head-of-ring injector: registers processor requests onto the W->E ring and collects E->W read responses.
// Optional read-latency monitor compiled in with GLB_RING_HEAD_PERF_EN.

package glb_ring_pkg;
  localparam int BANK_DATA_WIDTH = 64;
  localparam int GLB_ADDR_WIDTH  = 20;

  typedef struct packed {
    logic                         wr_en;
    logic [BANK_DATA_WIDTH/8-1:0] wr_strb;
    logic [GLB_ADDR_WIDTH-1:0]    wr_addr;
    logic [BANK_DATA_WIDTH-1:0]   wr_data;
    logic                         rd_en;
    logic [GLB_ADDR_WIDTH-1:0]    rd_addr;
    logic [BANK_DATA_WIDTH-1:0]   rd_data;
    logic                         rd_data_valid;
  } packet_t;
endpackage

module glb_proc_ring_head
  import glb_ring_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LAT_W           = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         proc_wr_en,
  input  logic [BANK_DATA_WIDTH/8-1:0] proc_wr_strb,
  input  logic [GLB_ADDR_WIDTH-1:0]    proc_wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0]   proc_wr_data,
  input  logic                         proc_rd_en,
  input  logic [GLB_ADDR_WIDTH-1:0]    proc_rd_addr,
  output logic                         proc_rd_ready,
  output logic [BANK_DATA_WIDTH-1:0]   proc_rd_data,
  output logic                         proc_rd_data_valid,
  output packet_t                      proc_packet_w2e_esto,
  input  packet_t                      proc_packet_e2w_esti,
  input  logic                         err_clr,
  output logic                         err_spurious,
  output logic [LAT_W-1:0]             perf_max_rd_lat
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  packet_t                    pkt_q, pkt_d;
  logic [BANK_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       err_q, err_d;

  logic rd_acc;
  logic rd_ret;
  logic spurious;
  logic ret_ok;

  assign proc_rd_ready = (cnt_q < CNT_MAX);
  assign rd_acc        = proc_rd_en & proc_rd_ready;
  assign rd_ret        = proc_packet_e2w_esti.rd_data_valid;
  // A return with nothing in flight is only legitimate if it pairs with a same-cycle accept.
  assign spurious      = rd_ret & (cnt_q == '0) & ~rd_acc;
  assign ret_ok        = rd_ret & ~spurious;

  // The ring terminates here, so returning request fields are dropped.
  logic unused_e2w;
  assign unused_e2w = ^{proc_packet_e2w_esti.wr_en, proc_packet_e2w_esti.wr_strb,
                        proc_packet_e2w_esti.wr_addr, proc_packet_e2w_esti.wr_data,
                        proc_packet_e2w_esti.rd_en, proc_packet_e2w_esti.rd_addr};

  always_comb begin
    pkt_d = '0;
    if (proc_wr_en) begin
      pkt_d.wr_en   = 1'b1;
      pkt_d.wr_strb = proc_wr_strb;
      pkt_d.wr_addr = proc_wr_addr;
      pkt_d.wr_data = proc_wr_data;
    end
    if (rd_acc) begin
      pkt_d.rd_en   = 1'b1;
      pkt_d.rd_addr = proc_rd_addr;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({rd_acc, ret_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rd_valid_d = rd_ret;
    rd_data_d  = rd_ret ? proc_packet_e2w_esti.rd_data : rd_data_q;
    err_d      = err_q;
    if (spurious)     err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      pkt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pkt_q      <= pkt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign proc_packet_w2e_esto = pkt_q;
  assign proc_rd_data         = rd_data_q;
  assign proc_rd_data_valid   = rd_valid_q;
  assign err_spurious         = err_q;

`ifdef GLB_RING_HEAD_PERF_EN
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  logic [LAT_W-1:0] stamp_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LAT_W-1:0] cyc_q;
  logic [LAT_W-1:0] max_lat_q, max_lat_d;
  logic [LAT_W-1:0] pop_stamp;
  logic [LAT_W-1:0] lat;

  // FIFO occupancy always equals cnt_q; when empty, a same-cycle push is popped through directly.
  assign pop_stamp = (cnt_q == '0) ? cyc_q : stamp_mem[rd_ptr_q];
  assign lat       = cyc_q - pop_stamp + LAT_W'(1);
  assign wr_ptr_d  = rd_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d  = ret_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_comb begin
    max_lat_d = err_clr ? '0 : max_lat_q;
    if (ret_ok && (lat > max_lat_d)) max_lat_d = lat;
  end

  always_ff @(posedge clk) begin
    if (rd_acc) stamp_mem[wr_ptr_q] <= cyc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cyc_q     <= '0;
      max_lat_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cyc_q     <= cyc_q + LAT_W'(1);
      max_lat_q <= max_lat_d;
    end
  end

  assign perf_max_rd_lat = max_lat_q;
`else
  assign perf_max_rd_lat = '0;
`endif

endmodule

// File: tb/tb_glb_proc_ring_head.sv
// Randomized + directed bench for glb_proc_ring_head against a queue-based reference model.
module tb_glb_proc_ring_head;
  import glb_ring_pkg::*;

  localparam int MAX_OUTSTANDING = 4;
  localparam int LAT_W           = 16;

  logic                         clk;
  logic                         reset;
  logic                         proc_wr_en;
  logic [BANK_DATA_WIDTH/8-1:0] proc_wr_strb;
  logic [GLB_ADDR_WIDTH-1:0]    proc_wr_addr;
  logic [BANK_DATA_WIDTH-1:0]   proc_wr_data;
  logic                         proc_rd_en;
  logic [GLB_ADDR_WIDTH-1:0]    proc_rd_addr;
  logic                         proc_rd_ready;
  logic [BANK_DATA_WIDTH-1:0]   proc_rd_data;
  logic                         proc_rd_data_valid;
  packet_t                      proc_packet_w2e_esto;
  packet_t                      proc_packet_e2w_esti;
  logic                         err_clr;
  logic                         err_spurious;
  logic [LAT_W-1:0]             perf_max_rd_lat;

  glb_proc_ring_head #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .LAT_W(LAT_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .proc_wr_en          (proc_wr_en),
    .proc_wr_strb        (proc_wr_strb),
    .proc_wr_addr        (proc_wr_addr),
    .proc_wr_data        (proc_wr_data),
    .proc_rd_en          (proc_rd_en),
    .proc_rd_addr        (proc_rd_addr),
    .proc_rd_ready       (proc_rd_ready),
    .proc_rd_data        (proc_rd_data),
    .proc_rd_data_valid  (proc_rd_data_valid),
    .proc_packet_w2e_esto(proc_packet_w2e_esto),
    .proc_packet_e2w_esti(proc_packet_e2w_esti),
    .err_clr             (err_clr),
    .err_spurious        (err_spurious),
    .perf_max_rd_lat     (perf_max_rd_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of issue times for reads in flight.
  int unsigned                stamps[$];
  int unsigned                now;
  packet_t                    exp_pkt;
  logic [BANK_DATA_WIDTH-1:0] exp_rdata;
  logic                       exp_rvalid;
  logic                       exp_err;
  int unsigned                exp_perf;
  int                         rd_pkt_cnt;
  int                         n_cmp;
  int                         n_mis;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string phase);
    check({phase, "_pkt"},    256'(proc_packet_w2e_esto), 256'(exp_pkt));
    check({phase, "_rvalid"}, 256'(proc_rd_data_valid),   256'(exp_rvalid));
    check({phase, "_rdata"},  256'(proc_rd_data),         256'(exp_rdata));
    check({phase, "_err"},    256'(err_spurious),         256'(exp_err));
    check({phase, "_perf"},   256'(perf_max_rd_lat),      256'(exp_perf));
  endtask

  task automatic cycle(input logic wen, input logic [7:0] strb, input logic [19:0] waddr,
                       input logic [63:0] wdata, input logic ren, input logic [19:0] raddr,
                       input logic ret, input logic [63:0] rdata, input logic clr);
    logic        ready_exp;
    logic        acc;
    logic        spur;
    int unsigned lat;
    @(negedge clk);
    proc_wr_en   = wen;
    proc_wr_strb = strb;
    proc_wr_addr = waddr;
    proc_wr_data = wdata;
    proc_rd_en   = ren;
    proc_rd_addr = raddr;
    err_clr      = clr;
    proc_packet_e2w_esti               = '0;
    proc_packet_e2w_esti.wr_en         = 1'($urandom);
    proc_packet_e2w_esti.wr_addr       = GLB_ADDR_WIDTH'($urandom);
    proc_packet_e2w_esti.rd_en         = 1'($urandom);
    proc_packet_e2w_esti.rd_data_valid = ret;
    proc_packet_e2w_esti.rd_data       = rdata;

    ready_exp = (stamps.size() < MAX_OUTSTANDING);
    check("rd_ready", 256'(proc_rd_ready), 256'(ready_exp));
    acc  = ren && ready_exp;
    spur = ret && (stamps.size() == 0) && !acc;

    exp_pkt = '0;
    if (wen) begin
      exp_pkt.wr_en   = 1'b1;
      exp_pkt.wr_strb = strb;
      exp_pkt.wr_addr = waddr;
      exp_pkt.wr_data = wdata;
    end
    if (acc) begin
      exp_pkt.rd_en   = 1'b1;
      exp_pkt.rd_addr = raddr;
    end
    exp_rvalid = ret;
    if (ret) exp_rdata = rdata;
    if (acc) stamps.push_back(now);
    lat = 0;
    if (ret && !spur) lat = now - stamps.pop_front() + 1;
    if (spur) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
`ifdef GLB_RING_HEAD_PERF_EN
    if (clr) exp_perf = 0;
    if (ret && !spur && lat > exp_perf) exp_perf = lat;
`endif

    @(posedge clk);
    #1;
    now++;
    if (proc_packet_w2e_esto.rd_en) rd_pkt_cnt++;
    check_outputs("cyc");
  endtask

  task automatic idle();
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b0, 20'h0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic rd(input logic [19:0] a);
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b1, a, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic ret(input logic [63:0] d);
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b0, 20'h0, 1'b1, d, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset                = 1'b0;
    proc_wr_en           = 1'b0;
    proc_wr_strb         = '0;
    proc_wr_addr         = '0;
    proc_wr_data         = '0;
    proc_rd_en           = 1'b0;
    proc_rd_addr         = '0;
    err_clr              = 1'b0;
    proc_packet_e2w_esti = '0;
    stamps.delete();
    exp_pkt    = '0;
    exp_rdata  = '0;
    exp_rvalid = 1'b0;
    exp_err    = 1'b0;
    exp_perf   = 0;
    #1;
    check_outputs("reset");
    check("reset_ready", 256'(proc_rd_ready), 256'(1));
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    now   = 0;
    rd_pkt_cnt = 0;
    reset = 1'b0;
    do_reset(3);

    repeat (4) idle();
    cycle(1'b1, 8'hFF, 20'h100, 64'hDEADBEEF_00000001, 1'b0, 20'h0, 1'b0, 64'h0, 1'b0);
    check("wr_inject_ready", 256'(proc_rd_ready), 256'(1));
    $display("write injection: addr=0x100 wr_en=%0d", proc_packet_w2e_esto.wr_en);

    rd(20'h40);
    repeat (3) idle();
    ret(64'h1234);
    check("roundtrip_data", 256'(proc_rd_data), 256'(64'h1234));
    idle();
    $display("read round trip: data=%0h perf=%0d", proc_rd_data, perf_max_rd_lat);

    rd_pkt_cnt = 0;
    repeat (6) rd(20'(32'h200 + $urandom_range(0, 255)));
    check("throttle_rd_pkts", 256'(rd_pkt_cnt), 256'(MAX_OUTSTANDING));
    check("throttle_ready_low", 256'(proc_rd_ready), 256'(0));
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b1, 20'h300, 1'b1, 64'h55, 1'b0);
    rd(20'h301);
    rd(20'h302);
    check("throttle_one_more", 256'(rd_pkt_cnt), 256'(MAX_OUTSTANDING + 1));
    $display("throttle: %0d read packets issued", rd_pkt_cnt);
    repeat (4) ret({$urandom, $urandom});

    rd(20'h10);
    rd(20'h11);
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b1, 20'h12, 1'b1, 64'h77, 1'b0);
    ret(64'h78);
    ret(64'h79);
    idle();
    $display("accept+return at cnt=2: ready=%0d", proc_rd_ready);

    ret(64'hABCD);
    check("spurious_set", 256'(err_spurious), 256'(1));
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b0, 20'h0, 1'b0, 64'h0, 1'b1);
    check("spurious_clr", 256'(err_spurious), 256'(0));
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b0, 20'h0, 1'b1, 64'hBEEF, 1'b1);
    check("spurious_set_wins", 256'(err_spurious), 256'(1));
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b0, 20'h0, 1'b0, 64'h0, 1'b1);
    $display("spurious/clear: err=%0d", err_spurious);

    rd(20'h20);
    rd(20'h21);
    rd(20'h22);
    do_reset(2);
    idle();
    ret(64'h5A5A);
    check("stale_return_err", 256'(err_spurious), 256'(1));
    $display("reset mid-flight: err=%0d ready=%0d", err_spurious, proc_rd_ready);
    cycle(1'b0, 8'h0, 20'h0, 64'h0, 1'b0, 20'h0, 1'b0, 64'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic r;
      if (stamps.size() != 0) r = ($urandom_range(0, 99) < 40);
      else                    r = ($urandom_range(0, 99) < 3);
      cycle(1'($urandom), 8'($urandom), 20'($urandom), {$urandom, $urandom},
            1'($urandom), 20'($urandom), r, {$urandom, $urandom},
            $urandom_range(0, 99) < 5);
    end
    $display("random phase: %0d cycles", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
